// File: rtl/rx_serial7.sv
// 7-bit serial receiver: start, 7 data bits LSB first, [even parity], stop.
// Optional parity bit enabled by defining RX7_PARITY_EN.
module rx_serial7 #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       eck,
  input  logic       ers,
  input  logic       eena,
  input  logic       erx,
  output logic [6:0] sd,
  output logic       sval,
  output logic       sferr,
  output logic       sperr,
  output logic       sbusy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef RX7_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH, PARITY} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [6:0]      sh_q, sh_d;
  logic [6:0]      sd_q, sd_d;
  logic            sval_q, sval_d;
  logic            sferr_q, sferr_d;
`ifdef RX7_PARITY_EN
  logic            sperr_q, sperr_d;
  logic            pbad_q, pbad_d;
`endif

  always_ff @(posedge eck) begin
    if (ers) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
      sd_q      <= '0;
      sval_q    <= 1'b0;
      sferr_q   <= 1'b0;
`ifdef RX7_PARITY_EN
      sperr_q   <= 1'b0;
      pbad_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q <= erx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      sd_q      <= sd_d;
      sval_q    <= sval_d;
      sferr_q   <= sferr_d;
`ifdef RX7_PARITY_EN
      sperr_q   <= sperr_d;
      pbad_q    <= pbad_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    sd_d    = sd_q;
    sval_d  = 1'b0;
    sferr_d = 1'b0;
`ifdef RX7_PARITY_EN
    sperr_d = 1'b0;
    pbad_d  = pbad_q;
`endif
    case (state_q)
      IDLE: begin
        if (eena && !rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL) begin
          cnt_d        = '0;
          sh_d[idx_q]  = rx_s_q;
          idx_d        = idx_q + 3'd1;
          if (idx_q == 3'd6) begin
`ifdef RX7_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef RX7_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          // Even parity: data ones plus parity bit must be even.
          pbad_d  = (^sh_q) ^ rx_s_q;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          if (rx_s_q) begin
            // Re-entering IDLE at the stop midpoint allows back-to-back frames.
            state_d = IDLE;
`ifdef RX7_PARITY_EN
            if (pbad_q) begin
              sperr_d = 1'b1;
            end else begin
              sd_d   = sh_q;
              sval_d = 1'b1;
            end
`else
            sd_d   = sh_q;
            sval_d = 1'b1;
`endif
          end else begin
            sferr_d = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sd    = sd_q;
  assign sval  = sval_q;
  assign sferr = sferr_q;
  assign sbusy = (state_q != IDLE);
`ifdef RX7_PARITY_EN
  assign sperr = sperr_q;
`else
  assign sperr = 1'b0;
`endif

endmodule

// File: tb/tb_rx_serial7.sv
// Directed bench for rx_serial7 at CLKS_PER_BIT=16; strobes are tallied by a
// negedge monitor and checked with immediate assertions in the main sequence.
module tb_rx_serial7;

  localparam int CPB = 16;
`ifdef RX7_PARITY_EN
  localparam int SVAL_LAT = 139 + CPB;
`else
  localparam int SVAL_LAT = 139;
`endif

  logic       eck = 1'b0;
  logic       ers, eena, erx;
  logic [6:0] sd;
  logic       sval, sferr, sperr, sbusy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int sval_cnt = 0, sferr_cnt = 0, sperr_cnt = 0;
  int dbl_cnt = 0, excl_cnt = 0;
  int sval_cyc = 0, t_start = 0;
  logic [6:0] sd_log [0:31];
  logic prev_strobe = 1'b0;
  int s0, f0, p0;

  rx_serial7 #(.CLKS_PER_BIT(CPB)) dut (
    .eck(eck), .ers(ers), .eena(eena), .erx(erx),
    .sd(sd), .sval(sval), .sferr(sferr), .sperr(sperr), .sbusy(sbusy)
  );

  always #5 eck = ~eck;
  always @(posedge eck) cyc <= cyc + 1;

  always @(negedge eck) begin
    if (sval) begin
      sd_log[sval_cnt[4:0]] = sd;
      sval_cnt = sval_cnt + 1;
      sval_cyc = cyc;
    end
    if (sferr) sferr_cnt = sferr_cnt + 1;
    if (sperr) sperr_cnt = sperr_cnt + 1;
    if ((int'(sval) + int'(sferr) + int'(sperr)) > 1) excl_cnt = excl_cnt + 1;
    if ((sval || sferr || sperr) && prev_strobe) dbl_cnt = dbl_cnt + 1;
    prev_strobe = sval || sferr || sperr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge eck);
  endtask

  task automatic send_bit(input logic b);
    erx = b;
    tick(CPB);
  endtask

  // par_flip inverts the even-parity bit when parity is compiled in.
  task automatic send_frame(input logic [6:0] d, input logic stop, input logic par_flip);
    t_start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 7; i++) send_bit(d[i]);
`ifdef RX7_PARITY_EN
    send_bit((^d) ^ par_flip);
`else
    if (par_flip) begin end
`endif
    send_bit(stop);
  endtask

  initial begin
    ers = 1'b1; eena = 1'b1; erx = 1'b1;
    tick(3);
    chk("rst_sd", 32'(sd), 32'h0);
    chk("rst_sval", 32'(sval), 32'h0);
    chk("rst_sferr", 32'(sferr), 32'h0);
    chk("rst_sperr", 32'(sperr), 32'h0);
    chk("rst_sbusy", 32'(sbusy), 32'h0);
    ers = 1'b0;
    tick(4);

    // Good frame 0x55
    send_frame(7'h55, 1'b1, 1'b0);
    tick(4);
    chk("f55_svalcnt", 32'(sval_cnt), 32'd1);
    chk("f55_sd", 32'(sd), 32'h55);
    chk("f55_sferr", 32'(sferr_cnt), 32'd0);
    chk("f55_lat_ok", 32'((sval_cyc - t_start) >= SVAL_LAT - 2 && (sval_cyc - t_start) <= SVAL_LAT + 2), 32'd1);
    chk("f55_idle_busy", 32'(sbusy), 32'h0);

    // False start: 4-cycle glitch
    s0 = sval_cnt; f0 = sferr_cnt;
    erx = 1'b0; tick(4); erx = 1'b1; tick(8);
    chk("glitch_busy", 32'(sbusy), 32'h0);
    tick(20);
    chk("glitch_sval", 32'(sval_cnt), 32'(s0));
    chk("glitch_sferr", 32'(sferr_cnt), 32'(f0));
    chk("glitch_sd", 32'(sd), 32'h55);

    // Framing error 0x2A, line held low afterwards
    send_frame(7'h2A, 1'b0, 1'b0);
    chk("ferr_cnt", 32'(sferr_cnt), 32'(f0 + 1));
    chk("ferr_sval", 32'(sval_cnt), 32'(s0));
    chk("ferr_sd", 32'(sd), 32'h55);
    tick(20);
    chk("ferr_busy_low", 32'(sbusy), 32'h1);
    erx = 1'b1; tick(4);
    chk("ferr_busy_rel", 32'(sbusy), 32'h0);
    chk("ferr_cnt_once", 32'(sferr_cnt), 32'(f0 + 1));

    // Back-to-back 0x00 then 0x7F
    s0 = sval_cnt;
    send_frame(7'h00, 1'b1, 1'b0);
    send_frame(7'h7F, 1'b1, 1'b0);
    tick(4);
    chk("b2b_cnt", 32'(sval_cnt), 32'(s0 + 2));
    chk("b2b_first", 32'(sd_log[s0[4:0]]), 32'h00);
    chk("b2b_second", 32'(sd_log[5'(s0 + 1)]), 32'h7F);
    chk("b2b_sd", 32'(sd), 32'h7F);

    // Reset in the middle of data bit 3 of 0x13
    s0 = sval_cnt; f0 = sferr_cnt;
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    erx = 1'b0; tick(CPB / 2);
    ers = 1'b1; erx = 1'b1;
    tick(1);
    chk("abort_sd", 32'(sd), 32'h0);
    chk("abort_sval", 32'(sval), 32'h0);
    chk("abort_sferr", 32'(sferr), 32'h0);
    chk("abort_sperr", 32'(sperr), 32'h0);
    chk("abort_sbusy", 32'(sbusy), 32'h0);
    ers = 1'b0;
    tick(30);
    chk("abort_nostrobe", 32'(sval_cnt + sferr_cnt), 32'(s0 + f0));
    send_frame(7'h13, 1'b1, 1'b0);
    tick(4);
    chk("post_abort_cnt", 32'(sval_cnt), 32'(s0 + 1));
    chk("post_abort_sd", 32'(sd), 32'h13);

    // Receiver disabled: frame ignored
    s0 = sval_cnt;
    eena = 1'b0;
    send_frame(7'h3C, 1'b1, 1'b0);
    tick(4);
    chk("dis_cnt", 32'(sval_cnt), 32'(s0));
    chk("dis_sd", 32'(sd), 32'h13);
    eena = 1'b1;
    tick(4);

`ifdef RX7_PARITY_EN
    s0 = sval_cnt; p0 = sperr_cnt;
    send_frame(7'h07, 1'b1, 1'b1);
    tick(4);
    chk("par_bad_sperr", 32'(sperr_cnt), 32'(p0 + 1));
    chk("par_bad_sval", 32'(sval_cnt), 32'(s0));
    chk("par_bad_sd", 32'(sd), 32'h13);
    send_frame(7'h07, 1'b1, 1'b0);
    tick(4);
    chk("par_ok_sval", 32'(sval_cnt), 32'(s0 + 1));
    chk("par_ok_sd", 32'(sd), 32'h07);
    chk("par_ok_sperr", 32'(sperr_cnt), 32'(p0 + 1));
`else
    p0 = 0;
    chk("noparity_sperr", 32'(sperr_cnt), 32'(p0));
`endif

    chk("strobe_excl", 32'(excl_cnt), 32'd0);
    chk("strobe_double", 32'(dbl_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
